// File: rtl/y_receiver_if.sv
// Y-side four-phase handshake bundle: request, data word,
// parity bit and the receiver acknowledge.
interface y_receiver_if #(
  parameter int WIDTH = 32
);
  logic             YREQ;
  logic [WIDTH-1:0] YDATA;
  logic             YPARITY;
  logic             YACK;

  modport master (
    output YREQ,
    output YDATA,
    output YPARITY,
    input  YACK
  );

  modport slave (
    input  YREQ,
    input  YDATA,
    input  YPARITY,
    output YACK
  );
endinterface

// File: rtl/y_receiver.sv
// Four-phase Y-side receiver with parity check, sticky error
// reporting and a small receive FIFO drained by RVALID/RREADY.
module y_receiver #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  y_receiver_if.slave              y,
  input  logic                     PARITYSEL,
  output logic [WIDTH-1:0]         RDATA,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     PERR,
  input  logic                     PERR_CLR,
  output logic [7:0]               ERRCNT
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t         state_q, state_d;
  logic           yack_q, yack_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           perr_q, perr_d;
  logic [7:0]     errcnt_q, errcnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic space, sample, par_ok, push, pop, perr_hit;

  // Space is judged on the pre-pop level, so full never accepts.
  assign space    = level_q < LW'(DEPTH);
  assign sample   = (state_q == S_IDLE) && y.YREQ && space;
  assign par_ok   = (^{y.YDATA, y.YPARITY}) == PARITYSEL;
  assign push     = sample && par_ok;
  assign perr_hit = sample && !par_ok;
  assign pop      = RREADY && (level_q != '0);

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    perr_d   = perr_q;
    errcnt_d = errcnt_q;
    unique case (state_q)
      S_IDLE: if (sample) state_d = S_ACK;
      S_ACK:  if (!y.YREQ) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    yack_d  = (state_d == S_ACK);
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    level_d = level_q + LW'(push) - LW'(pop);
    if (perr_hit) begin
      perr_d   = 1'b1;
      errcnt_d = PERR_CLR ? 8'd1 :
                 (errcnt_q == 8'hFF) ? 8'hFF :
                 errcnt_q + 8'd1;
    end else if (PERR_CLR) begin
      perr_d   = 1'b0;
      errcnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      yack_q   <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      perr_q   <= 1'b0;
      errcnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      yack_q   <= yack_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      perr_q   <= perr_d;
      errcnt_q <= errcnt_d;
    end
  end

  // Storage holds no reset; only pointers/level define contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= y.YDATA;
  end

  assign y.YACK = yack_q;
  assign RDATA  = mem_q[rptr_q];
  assign RVALID = (level_q != '0);
  assign LEVEL  = level_q;
  assign PERR   = perr_q;
  assign ERRCNT = errcnt_q;
endmodule

// File: tb/tb_y_receiver.sv
// Directed bench for y_receiver: vector table for the basic
// handshake/parity path plus sequences for full, reset, saturation.
module tb_y_receiver;
  logic        clk = 1'b0;
  logic        rst;
  logic        psel;
  logic        rready;
  logic        pclr;
  logic [31:0] rdata;
  logic        rvalid;
  logic [2:0]  level;
  logic        perr;
  logic [7:0]  errcnt;
  int          tests = 0;
  int          fails = 0;

  y_receiver_if #(.WIDTH(32)) yif ();

  y_receiver #(.WIDTH(32), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .y        (yif.slave),
    .PARITYSEL(psel),
    .RDATA    (rdata),
    .RVALID   (rvalid),
    .RREADY   (rready),
    .LEVEL    (level),
    .PERR     (perr),
    .PERR_CLR (pclr),
    .ERRCNT   (errcnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        yreq;
    logic [31:0] ydata;
    logic        ypar;
    logic        psel;
    logic        rready;
    logic        pclr;
    logic        e_yack;
    logic        e_rvalid;
    logic [2:0]  e_level;
    logic [31:0] e_rdata;
    logic        e_perr;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Full four-phase transfer with even parity, bounded waits.
  task automatic xfer(logic [31:0] d, logic p);
    yif.YDATA   = d;
    yif.YPARITY = p;
    yif.YREQ    = 1'b1;
    for (int i = 0; i < 10 && !yif.YACK; i++) step();
    chk("xfer_ack_up", yif.YACK, 1);
    yif.YREQ = 1'b0;
    for (int i = 0; i < 10 && yif.YACK; i++) step();
    chk("xfer_ack_dn", yif.YACK, 0);
  endtask

  logic [31:0] exp_q[4];

  initial begin
    rst = 1'b1;
    yif.YREQ = 1'b0;
    yif.YDATA = '0;
    yif.YPARITY = 1'b0;
    psel = 1'b0;
    rready = 1'b0;
    pclr = 1'b0;

    vecs[0]  = '{1, 32'h3, 0, 0, 0, 0, 1, 1, 1, 32'h3, 0, 0};
    vecs[1]  = '{1, 32'h3, 0, 0, 0, 0, 1, 1, 1, 32'h3, 0, 0};
    vecs[2]  = '{0, 32'h0, 0, 0, 0, 0, 0, 1, 1, 32'h3, 0, 0};
    vecs[3]  = '{1, 32'h1, 1, 1, 0, 0, 1, 1, 1, 32'h3, 1, 1};
    vecs[4]  = '{0, 32'h0, 0, 1, 0, 0, 0, 1, 1, 32'h3, 1, 1};
    vecs[5]  = '{0, 32'h0, 0, 1, 0, 1, 0, 1, 1, 32'h3, 0, 0};
    vecs[6]  = '{1, 32'h5, 1, 1, 0, 0, 1, 1, 2, 32'h3, 0, 0};
    vecs[7]  = '{0, 32'h0, 0, 0, 1, 0, 0, 1, 1, 32'h5, 0, 0};
    vecs[8]  = '{0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0};
    vecs[9]  = '{0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0, 0};
    vecs[10] = '{1, 32'h7, 0, 0, 0, 1, 1, 0, 0, 32'h0, 1, 1};
    vecs[11] = '{0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1};

    #12;
    chk("rst_yack", yif.YACK, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_level", level, 0);
    chk("rst_perr", perr, 0);
    chk("rst_errcnt", errcnt, 0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      yif.YREQ    = vecs[i].yreq;
      yif.YDATA   = vecs[i].ydata;
      yif.YPARITY = vecs[i].ypar;
      psel        = vecs[i].psel;
      rready      = vecs[i].rready;
      pclr        = vecs[i].pclr;
      step();
      chk($sformatf("v%0d_yack", i), yif.YACK, vecs[i].e_yack);
      chk($sformatf("v%0d_rvalid", i), rvalid, vecs[i].e_rvalid);
      chk($sformatf("v%0d_level", i), level, vecs[i].e_level);
      chk($sformatf("v%0d_perr", i), perr, vecs[i].e_perr);
      chk($sformatf("v%0d_errcnt", i), errcnt, vecs[i].e_cnt);
      if (vecs[i].e_rvalid)
        chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
    end
    yif.YREQ = 1'b0;
    rready = 1'b0;
    pclr = 1'b0;
    psel = 1'b0;

    // Fill, blocked fifth request, pop-with-full edge.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      xfer(32'hA0 + i, ^(32'hA0 + i));
    end
    chk("full_level", level, 4);
    yif.YDATA = 32'hB5;
    yif.YPARITY = ^yif.YDATA;
    yif.YREQ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_block_yack", yif.YACK, 0);
      chk("full_block_level", level, 4);
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("popfull_yack", yif.YACK, 0);
    chk("popfull_level", level, 3);
    chk("popfull_rdata", rdata, 32'hA1);
    step();
    chk("late_accept_yack", yif.YACK, 1);
    chk("late_accept_level", level, 4);
    yif.YREQ = 1'b0;
    step();
    chk("late_accept_drop", yif.YACK, 0);
    exp_q = '{32'hA1, 32'hA2, 32'hA3, 32'hB5};
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_rdata", i), rdata, exp_q[i]);
      rready = 1'b1;
      step();
      rready = 1'b0;
    end
    chk("drain_level", level, 0);
    chk("drain_rvalid", rvalid, 0);

    // Asynchronous reset while acknowledging with two words held.
    do_reset();
    xfer(32'h11, ^32'h11);
    yif.YDATA = 32'h22;
    yif.YPARITY = ^yif.YDATA;
    yif.YREQ = 1'b1;
    step();
    chk("pre_rst_yack", yif.YACK, 1);
    chk("pre_rst_level", level, 2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_yack", yif.YACK, 0);
    chk("async_rst_rvalid", rvalid, 0);
    chk("async_rst_level", level, 0);
    #1 rst = 1'b0;
    step();
    chk("post_rst_yack", yif.YACK, 1);
    chk("post_rst_level", level, 1);
    chk("post_rst_rdata", rdata, 32'h22);
    yif.YREQ = 1'b0;
    step();

    // Error counter saturation; odd data with even parity fails.
    do_reset();
    for (int i = 0; i < 256; i++) xfer(32'h1, 1'b0);
    chk("sat_errcnt", errcnt, 255);
    chk("sat_perr", perr, 1);
    chk("sat_level", level, 0);
    chk("sat_rvalid", rvalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
